pc_unit: RTL
============

Name: pc_unit

Overview:
- Program-counter stage directly downstream of the conditional-branch decision logic.
- Consumes the branch-taken flag plus jump/jump-register requests and produces the fetch address each cycle.
- Implements an optional single MIPS branch delay slot, stall hold and a sticky halt.
- Keeps cycle, jump and taken-branch statistics counters for the board display.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DELAY_SLOT, 1, 1 = one architectural delay slot executes before redirect; 0 = redirect on the next cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and pending state this cycle.
- halt  in  1  syscall-halt request from decode; sticky once accepted.
- pcsel  in  1  conditional branch taken, for the instruction at pc_out.
- br_imm  in  16  branch immediate of the instruction at pc_out.
- jump  in  1  J/JAL for the instruction at pc_out.
- jump_idx  in  26  J-type index field.
- jr  in  1  JR/JALR for the instruction at pc_out.
- jr_target  in  32  register-file rs value.
- pc_out  out  32  current fetch address.
- pc_plus4  out  32  pc_out + 4, combinational (link value).
- halted  out  1  halt state.
- slot_active  out  1  the instruction at pc_out is a delay slot.
- cycle_cnt  out  32  cycles while not halted.
- jump_cnt  out  32  accepted jump/jr redirects.
- br_taken_cnt  out  32  accepted taken conditional branches.

Behaviour:
- Reset (async, rst_n=0): pc_out=RESET_PC, state=RUN, pending target=0, halted=0, slot_active=0, all counters=0.
- States:
  - RUN: normal sequencing.
  - SLOT: delay slot in flight, target pending. Reachable only if DELAY_SLOT=1.
  - HALT: terminal until reset.
- Redirect target when multiple requests are asserted: jr > jump > pcsel.
  - jr: jr_target.
  - jump: {pc_plus4[31:28], jump_idx, 2'b00}.
  - pcsel: pc_plus4 + (sign-extend(br_imm) << 2), 32-bit wrap-around.
- Cycle priority: halt > stall > redirect > sequential.
- halt=1 in RUN or SLOT: next state HALT, pc_out holds. halted=1 from the next edge. Counters freeze from that edge; the halt cycle itself is counted. Redirect requests in that cycle are dropped.
- stall=1, no halt: pc_out, state, pending target and redirect counters hold. cycle_cnt still increments. Redirect requests are ignored; decode re-presents them after the stall.
- RUN with a redirect request:
  - DELAY_SLOT=1: pc_out <= pc_plus4, latch target, go to SLOT, slot_active=1 next cycle.
  - DELAY_SLOT=0: pc_out <= target, stay in RUN.
  - Either way, increment jump_cnt (jr or jump) or br_taken_cnt (pcsel only) by exactly 1.
- RUN with no request: pc_out <= pc_plus4.
- SLOT, no stall/halt: pc_out <= pending target, go to RUN, slot_active=0. pcsel/jump/jr in a delay slot are ignored and not counted.
- Stall in SLOT keeps slot_active=1 and keeps the pending target.
- HALT: every input except rst_n is ignored. Outputs stay constant.
- Counters wrap modulo 2^32. Misaligned jr_target is passed through unchanged; alignment faults are not this block's job.
- Timing: the branch inputs are combinational from the same cycle, giving single-cycle latency from request to pc_out update.

Decomposition:
- Shared cpu package holds:
  - state enum {RUN, SLOT, HALT};
  - RESET_PC default constant;
  - helper function for sign-extend-shift-by-2.
- One natural sub-module: pc_next_calc, purely combinational. It takes pc, the request vector, br_imm, jump_idx and jr_target, and returns the target plus a redirect-valid flag. The top level holds the state register, PC register and counters.

Test Plan:
- Reset then 4 free cycles, DELAY_SLOT=1 → pc_out 0,4,8,C,10; cycle_cnt=4 at the 4th edge; other counters 0.
- At pc=0x10: pcsel=1, br_imm=16'hFFFC → next pc 0x14 with slot_active=1, then 0x04; br_taken_cnt=1. The same stimulus with DELAY_SLOT=0 → next pc 0x04.
- At pc=0x14: jump=1 and jr=1 together, jr_target=0x100 → pc 0x18 (slot), then 0x100; jump_cnt=1. A pcsel pulse during the slot cycle changes nothing and is not counted.
- In SLOT, stall held 3 cycles → pc_out, slot_active and pending target unchanged; cycle_cnt +3. After release, pc goes to the target.
- halt=1 at pc=0x20 with pcsel=1 → pc_out stays 0x20, halted=1, counters frozen for 10 cycles, br_taken_cnt unchanged.
- rst_n pulsed low asynchronously mid-SLOT (between edges) → outputs return to reset values immediately; the pending target is discarded and the sequence restarts from RESET_PC.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter stage.
//   pc_state_e     : sequencing state (RUN, SLOT, HALT)
//   redirect_req_t : the three redirect requests for the instruction at pc_out
//   sext_shl2      : branch immediate -> byte offset
package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SLOT = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  typedef struct packed {
    logic jr;
    logic jump;
    logic pcsel;
  } redirect_req_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Statistics counter slots
  localparam int CNT_CYCLE = 0;
  localparam int CNT_JUMP  = 1;
  localparam int CNT_BR    = 2;
  localparam int NUM_CNT   = 3;

  // Word offset of a conditional branch, sign-extended to 32 bits.
  function automatic logic [31:0] sext_shl2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Decode <-> PC stage bundle.
//   master : decode side, drives requests, observes fetch address and stats
//   slave  : pc_unit side
interface pc_unit_if;
  logic        stall;
  logic        halt;
  logic        pcsel;
  logic [15:0] br_imm;
  logic        jump;
  logic [25:0] jump_idx;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        slot_active;
  logic [31:0] cycle_cnt;
  logic [31:0] jump_cnt;
  logic [31:0] br_taken_cnt;

  modport master (
    output stall, halt, pcsel, br_imm, jump, jump_idx, jr, jr_target,
    input  pc_out, pc_plus4, halted, slot_active, cycle_cnt, jump_cnt, br_taken_cnt
  );

  modport slave (
    input  stall, halt, pcsel, br_imm, jump, jump_idx, jr, jr_target,
    output pc_out, pc_plus4, halted, slot_active, cycle_cnt, jump_cnt, br_taken_cnt
  );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational redirect target selection.
//   pc        : current fetch address
//   req       : jr / jump / pcsel requests
//   br_imm, jump_idx, jr_target : target operands
//   target    : selected redirect address (jr > jump > pcsel)
//   redirect  : any request present
//   is_jump   : winning request is jr or jump
//   is_branch : winning request is the conditional branch
module pc_next_calc
  import pc_unit_pkg::*;
(
  input  logic [31:0]   pc,
  input  redirect_req_t req,
  input  logic [15:0]   br_imm,
  input  logic [25:0]   jump_idx,
  input  logic [31:0]   jr_target,
  output logic [31:0]   target,
  output logic          redirect,
  output logic          is_jump,
  output logic          is_branch
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    target = pc_plus4 + sext_shl2(br_imm);
    if (req.jr) begin
      target = jr_target;
    end else if (req.jump) begin
      target = {pc_plus4[31:28], jump_idx, 2'b00};
    end
  end

  assign redirect  = req.jr | req.jump | req.pcsel;
  assign is_jump   = req.jr | req.jump;
  assign is_branch = req.pcsel & ~is_jump;

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: sequencing, optional delay slot, stall, sticky halt
// and statistics counters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : pc_unit_if.slave (requests in; pc_out, pc_plus4, halted,
//                slot_active and the three counters out)
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          DELAY_SLOT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_unit_if.slave  bus
);

  pc_state_e        state_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      target_reg;

  redirect_req_t    req;
  logic [31:0]      calc_target;
  logic             calc_redirect;
  logic             calc_is_jump;
  logic             calc_is_branch;
  logic             run_advance;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [NUM_CNT-1:0][31:0] cnt_val;

  assign req = '{jr: bus.jr, jump: bus.jump, pcsel: bus.pcsel};

  pc_next_calc u_next_calc (
    .pc        (pc_reg),
    .req       (req),
    .br_imm    (bus.br_imm),
    .jump_idx  (bus.jump_idx),
    .jr_target (bus.jr_target),
    .target    (calc_target),
    .redirect  (calc_redirect),
    .is_jump   (calc_is_jump),
    .is_branch (calc_is_branch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_RUN;
      pc_reg     <= RESET_PC;
      target_reg <= 32'h0000_0000;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (bus.halt) begin
            state_reg <= ST_HALT;
          end else if (bus.stall) begin
            state_reg <= ST_RUN;
          end else if (calc_redirect) begin
            if (DELAY_SLOT != 0) begin
              // The sequential instruction after the branch still executes.
              pc_reg     <= pc_reg + 32'd4;
              target_reg <= calc_target;
              state_reg  <= ST_SLOT;
            end else begin
              pc_reg <= calc_target;
            end
          end else begin
            pc_reg <= pc_reg + 32'd4;
          end
        end
        ST_SLOT: begin
          // Requests from the slot instruction itself are deliberately dropped.
          if (bus.halt) begin
            state_reg <= ST_HALT;
          end else if (!bus.stall) begin
            pc_reg    <= target_reg;
            state_reg <= ST_RUN;
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  // Redirects only count when they are actually accepted in RUN.
  assign run_advance = (state_reg == ST_RUN) & ~bus.halt & ~bus.stall;

  always_comb begin
    cnt_inc            = '0;
    cnt_inc[CNT_CYCLE] = (state_reg != ST_HALT);
    cnt_inc[CNT_JUMP]  = run_advance & calc_is_jump;
    cnt_inc[CNT_BR]    = run_advance & calc_is_branch;
  end

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= 32'h0000_0000;
        end else if (cnt_inc[gi]) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign bus.pc_out       = pc_reg;
  assign bus.pc_plus4     = pc_reg + 32'd4;
  assign bus.halted       = (state_reg == ST_HALT);
  assign bus.slot_active  = (state_reg == ST_SLOT);
  assign bus.cycle_cnt    = cnt_val[CNT_CYCLE];
  assign bus.jump_cnt     = cnt_val[CNT_JUMP];
  assign bus.br_taken_cnt = cnt_val[CNT_BR];

endmodule
